mssd_frame_ctrl: RTL and testbench
==================================

MSSD_FRAME_CTRL -- requirements
Module: mssd_frame_ctrl

Interface
REQ-001 Parameter MULT_SHIFT, default 3: payload length = count << MULT_SHIFT (x8 bits per count unit).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 serIn  in  1  serial input stream, sampled on rising clk.
REQ-005 en  in  1  advance enable; when 0 all state, counters and header hold.
REQ-006 hdr  out  6  captured header; [1:0] = destination port, [5:2] = count.
REQ-007 po  out  4  per-port payload data; only po[port] carries data, others 0.
REQ-008 pv  out  4  per-port data valid, one-hot or zero.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  frame complete, high while in DONE.

Function
REQ-011 FSM states SHALL be IDLE, SYNC, HEADER, PAYLOAD, DONE; transitions occur only on edges with en=1.
REQ-012 IDLE: serIn=1 -> SYNC; else stay.
REQ-013 SYNC: serIn=0 -> HEADER (start pattern "10"); serIn=1 -> stay in SYNC.
REQ-014 HEADER: 6 bits shifted LSB-first, hdr <= {serIn, hdr[5:1]}; 3-bit bit counter 0..5.
REQ-015 On 6th header bit: count!=0 -> PAYLOAD; count==0 -> DONE (no payload, no pv).
REQ-016 Header bit counter and payload counter SHALL clear to 0 on entry to HEADER and PAYLOAD respectively.
REQ-017 PAYLOAD: 7-bit counter 0..len-1, len = count<<MULT_SHIFT (max 120); at counter==len-1 with en=1 -> DONE; no wrap.
REQ-018 pv and po registered: each PAYLOAD cycle with en=1, next edge sets pv[port]=1, po[port]=serIn; all other bits 0.
REQ-019 pv SHALL be 0 after any edge not in PAYLOAD with en=1 (stall cycles produce no valid).
REQ-020 Latency: serIn payload bit appears on po[port] exactly 1 cycle after sampling.
REQ-021 Exactly len pv pulses per frame regardless of en pattern.
REQ-022 done is combinational from state==DONE; the last pv pulse coincides with the first done cycle.
REQ-023 DONE -> IDLE on next edge with en=1; serIn ignored in DONE.
REQ-024 hdr SHALL hold its value from end of HEADER until next entry to HEADER.
REQ-025 Counter compare SHALL be >= (not ==) against len-1 so a corrupted counter cannot overrun.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, hdr=0, po=0, pv=0, counters 0, busy=0, done=0, at any point including mid-frame.
REQ-027 After rst release, the first rising edge with en=1 evaluates IDLE normally.

Structure
REQ-028 Shared package mssd_pkg SHALL hold the state enum, HDR_W=6, CNT_W=7, NPORTS=4.
REQ-029 One sub-module mssd_hdr_shift: 6-bit LSB-first shift register with enable and async active-low clear.
REQ-030 Port steering (decode of hdr[1:0] to one-hot) SHALL be inline, no tri-states.

Verification
REQ-031 serIn 1,0, hdr bits of 6'b000110, payload 10110010 -> pv=4'b0100 for 8 cycles, po[2] = 1,0,1,1,0,0,1,0 (LSB-first order as sent), done high with 8th pv.
REQ-032 serIn 1,0, hdr 6'b000011 -> hdr=6'b000011, no pv, done high the cycle after last header bit, busy=0 next cycle.
REQ-033 hdr 6'b111101 -> pv=4'b0010 for exactly 120 cycles, payload counter peaks at 119, then DONE.
REQ-034 en=0 for 3 cycles mid-header and 3 cycles mid-payload (hdr 6'b000100) -> state/hdr hold, pv=0 during stalls, total pv count 8 on port 0.
REQ-035 serIn 1,1,1,0 then header -> header capture begins the edge after the 0; no spurious capture during repeated 1s.
REQ-036 rst=0 at payload bit 4 -> all outputs 0 asynchronously; following clean frame completes correctly.

Source files
------------

// File: rtl/mssd_pkg.sv
// mssd_pkg: shared state encoding and widths for the frame controller
package mssd_pkg;
    localparam int HDR_W  = 6;
    localparam int CNT_W  = 7;
    localparam int NPORTS = 4;
    typedef enum logic [2:0] {IDLE, SYNC, HEADER, PAYLOAD, DONE} state_t;
endpackage

// File: rtl/mssd_hdr_shift.sv
// mssd_hdr_shift: LSB-first header shift register
//   clk, rst (async active-low clear), en (shift enable), d (serial bit), q (captured header)
module mssd_hdr_shift
    import mssd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    output logic [HDR_W-1:0] q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= '0;
        else if (en) q <= {d, q[HDR_W-1:1]};
endmodule

// File: rtl/mssd_frame_ctrl.sv
// mssd_frame_ctrl: serial frame receiver steering payload bits to one of four ports
//   clk, rst (async active-low), serIn (serial stream), en (advance enable)
//   hdr (captured header: [1:0] port, [5:2] count), po/pv (per-port data/valid)
//   busy (not idle), done (frame complete)
module mssd_frame_ctrl
    import mssd_pkg::*;
#(
    parameter int MULT_SHIFT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serIn,
    input  logic              en,
    output logic [HDR_W-1:0]  hdr,
    output logic [NPORTS-1:0] po,
    output logic [NPORTS-1:0] pv,
    output logic              busy,
    output logic              done
);
    state_t            state, state_nx;
    logic [2:0]        hdr_cnt;
    logic [CNT_W-1:0]  pay_cnt, len;
    logic [3:0]        cnt_nx;
    logic [NPORTS-1:0] sel;
    // count field as it will read after the bit being shifted in this cycle
    assign cnt_nx = {serIn, hdr[HDR_W-1:3]};
    assign len    = CNT_W'(hdr[HDR_W-1:2]) << MULT_SHIFT;
    assign sel    = NPORTS'(1) << hdr[1:0];
    assign busy   = state != IDLE;
    assign done   = state == DONE;
    mssd_hdr_shift u_shift (
        .clk(clk),
        .rst(rst),
        .en (en && state == HEADER),
        .d  (serIn),
        .q  (hdr)
    );
    always_comb begin
        state_nx = state;
        if (en)
            case (state)
                IDLE:    state_nx = serIn ? SYNC : IDLE;
                SYNC:    state_nx = serIn ? SYNC : HEADER;
                HEADER:  state_nx = hdr_cnt >= 3'd5 ? (cnt_nx != 4'd0 ? PAYLOAD : DONE) : HEADER;
                // >= so a corrupted counter still terminates the frame
                PAYLOAD: state_nx = pay_cnt >= len - CNT_W'(1) ? DONE : PAYLOAD;
                default: state_nx = IDLE;
            endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state   <= IDLE;
            hdr_cnt <= '0;
            pay_cnt <= '0;
            pv      <= '0;
            po      <= '0;
        end else begin
            pv <= '0;
            po <= '0;
            if (en) begin
                state   <= state_nx;
                hdr_cnt <= state == HEADER ? hdr_cnt + 3'd1 : 3'd0;
                pay_cnt <= state == PAYLOAD ? pay_cnt + CNT_W'(1) : CNT_W'(0);
                if (state == PAYLOAD) begin
                    pv <= sel;
                    po <= serIn ? sel : '0;
                end
            end
        end
endmodule

// File: tb/tb_mssd_frame_ctrl.sv
// tb_mssd_frame_ctrl: scoreboard bench for the serial frame controller
module tb_mssd_frame_ctrl;
    logic       clk, rst, serIn, en;
    logic [5:0] hdr;
    logic [3:0] po, pv;
    logic       busy, done;
    logic [7:0] sb[$];
    logic [5:0] hm;
    int         passed = 0, total = 0, pv_cnt = 0;

    mssd_frame_ctrl #(.MULT_SHIFT(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .serIn(serIn),
        .en   (en),
        .hdr  (hdr),
        .po   (po),
        .pv   (pv),
        .busy (busy),
        .done (done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    always @(negedge clk)
        if (pv !== 4'b0) begin
            pv_cnt++;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected: got pv=%b po=%b expected no valid", pv, po);
            end else chk("payload {pv,po}", {24'b0, pv, po}, {24'b0, sb.pop_front()});
        end

    task automatic send(input logic b, input logic e);
        serIn = b;
        en    = e;
        @(posedge clk);
        #1;
    endtask

    task automatic hbit(input logic b);
        hm = {b, hm[5:1]};
        send(b, 1'b1);
    endtask

    task automatic start();
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
    endtask

    task automatic send_hdr(input logic [5:0] h);
        for (int i = 0; i < 6; i++) hbit(h[i]);
    endtask

    task automatic pay(input logic b, input logic [3:0] oh);
        sb.push_back({oh, b ? oh : 4'b0});
        send(b, 1'b1);
    endtask

    task automatic finish_frame(input int n);
        send(1'b1, 1'b1);
        chk("busy after done", {31'b0, busy}, 32'd0);
        chk("pv count", pv_cnt, n);
        chk("sb drained", sb.size(), 0);
        pv_cnt = 0;
    endtask

    initial begin
        logic [7:0] pl;
        logic [3:0] s;
        rst = 0; en = 0; serIn = 0; hm = 6'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {18'b0, hdr, po, pv, busy, done}, 32'd0);
        rst = 1;

        // nominal frame, port 2, count 1
        start();
        send_hdr(6'b000110);
        chk("t1 hdr", {26'b0, hdr}, 32'h06);
        chk("t1 busy", {31'b0, busy}, 32'd1);
        pl = 8'b10110010;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) chk("t1 done early", {31'b0, done}, 32'd0);
            pay(pl[i], 4'b0100);
        end
        chk("t1 done with last pv", {30'b0, done, pv == 4'b0100}, 32'd3);
        finish_frame(8);

        // zero-count frame goes straight to DONE
        start();
        send_hdr(6'b000011);
        chk("t2 done", {31'b0, done}, 32'd1);
        chk("t2 hdr/pv", {22'b0, hdr, pv}, {22'b0, 6'b000011, 4'b0});
        finish_frame(0);
        send(1'b0, 1'b1);
        chk("t2 stays idle", {31'b0, busy}, 32'd0);

        // maximum length frame, port 1
        start();
        send_hdr(6'b111101);
        for (int i = 0; i < 120; i++) begin
            if (i == 119) chk("t3 done early", {31'b0, done}, 32'd0);
            pay(1'($urandom), 4'b0010);
        end
        chk("t3 done", {31'b0, done}, 32'd1);
        finish_frame(120);

        // stalls mid-header and mid-payload, port 0
        start();
        hbit(1'b0); hbit(1'b0); hbit(1'b1);
        for (int i = 0; i < 3; i++) begin
            send(1'($urandom), 1'b0);
            chk("t4 hdr stall", {26'b0, hdr}, {26'b0, hm});
            chk("t4 hdr stall pv", {27'b0, busy, pv}, 32'h10);
        end
        hbit(1'b0); hbit(1'b0); hbit(1'b0);
        chk("t4 hdr", {26'b0, hdr}, 32'h04);
        s = 4'b1101;
        for (int i = 0; i < 4; i++) pay(s[i], 4'b0001);
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0);
            chk("t4 pay stall pv", {27'b0, done, pv}, 32'd0);
        end
        s = 4'b0110;
        for (int i = 0; i < 4; i++) pay(s[i], 4'b0001);
        chk("t4 done", {31'b0, done}, 32'd1);
        finish_frame(8);

        // repeated sync ones before the start zero
        send(1'b1, 1'b1); send(1'b1, 1'b1); send(1'b1, 1'b1);
        chk("t5 sync busy", {31'b0, busy}, 32'd1);
        send(1'b0, 1'b1);
        send_hdr(6'b000110);
        chk("t5 hdr", {26'b0, hdr}, 32'h06);
        pl = 8'hA5;
        for (int i = 0; i < 8; i++) pay(pl[i], 4'b0100);
        chk("t5 done", {31'b0, done}, 32'd1);
        finish_frame(8);

        // asynchronous reset mid-payload, then a clean frame
        start();
        send_hdr(6'b000110);
        for (int i = 0; i < 4; i++) pay(1'b1, 4'b0100);
        #2 rst = 0;
        #1;
        chk("t6 async reset", {18'b0, hdr, po, pv, busy, done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1;
        sb.delete();
        pv_cnt = 0;
        hm = 6'b0;
        start();
        send_hdr(6'b001001);
        chk("t6 hdr", {26'b0, hdr}, 32'h09);
        for (int i = 0; i < 16; i++) pay(1'(i % 3 == 0), 4'b0010);
        chk("t6 done", {31'b0, done}, 32'd1);
        finish_frame(16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
